// File: rtl/branch_pred_pkg.sv
// Shared definitions for the fetch-stage branch predictor: opcode, counter
// encodings and the saturating-counter / B-immediate helpers.
package branch_pred_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        BP_SNT = 2'd0,
        BP_WNT = 2'd1,
        BP_WT  = 2'd2,
        BP_ST  = 2'd3
    } bp_cnt_e;

    // Two-bit counter step; never wraps between the strong states.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != BP_ST) res = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

    function automatic logic [63:0] b_offset(input logic [31:0] ir);
        return {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/branch_pred_if.sv
// Fetch/ID-side signal bundle of the branch predictor. The core drives the
// master side, the predictor sits on the slave side.
interface branch_pred_if #(
    parameter int IDX_W = 8
);
    logic [63:0]      if_pc;
    logic [31:0]      if_ir;
    logic             if_valid;
    logic             stall_if;
    logic             flush_if;
    logic             pred_taken_if;
    logic [63:0]      pred_addr_if;
    logic             pr_taken;
    logic [IDX_W-1:0] pr_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    modport master (
        output if_pc, if_ir, if_valid, stall_if, flush_if,
        output upd_valid, upd_idx, upd_taken,
        input  pred_taken_if, pred_addr_if, pr_taken, pr_idx
    );

    modport slave (
        input  if_pc, if_ir, if_valid, stall_if, flush_if,
        input  upd_valid, upd_idx, upd_taken,
        output pred_taken_if, pred_addr_if, pr_taken, pr_idx
    );
endinterface

// File: rtl/branch_pred_bht_array.sv
// Table of 2-bit saturating counters with synchronous reset, read-modify-write
// training and same-cycle forwarding of the training result to the read port.
module bht_array
    import branch_pred_pkg::*;
#(
    parameter int         ENTRIES  = 256,
    parameter int         IDX_W    = 8,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt_reg  [ENTRIES];
    logic [1:0] cnt_next [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_cnt
            assign cnt_next[gi] = (wr_en && wr_idx == IDX_W'(gi))
                                ? sat_update(cnt_reg[gi], wr_taken)
                                : cnt_reg[gi];
        end
    endgenerate

    // Reset wins over a coincident update, so that update is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (srst) cnt_reg[i] <= CNT_INIT;
            else      cnt_reg[i] <= cnt_next[i];
        end
    end

    // cnt_next already carries the trained value on an index hit (forwarding).
    assign rd_cnt = srst ? cnt_reg[rd_idx] : cnt_next[rd_idx];

endmodule

// File: rtl/branch_pred.sv
// Fetch-stage branch predictor: decode, index hash, target add and IF/ID
// prediction registers. Define BP_GSHARE_EN to XOR a global history into the index.
module branch_pred
    import branch_pred_pkg::*;
#(
    parameter int         BHT_ENTRIES = 256,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         GHR_BITS    = 8,
    localparam int        IDX_W       = $clog2(BHT_ENTRIES)
) (
    input logic         clk,
    input logic         rst,
    branch_pred_if.slave bus
);

    generate
        if (BHT_ENTRIES < 4 || (1 << IDX_W) != BHT_ENTRIES || GHR_BITS > IDX_W || GHR_BITS < 2) begin : g_bad_cfg
            $error("branch_pred: illegal BHT_ENTRIES/GHR_BITS combination");
        end
    endgenerate

    logic             is_br;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] idx;
    logic [1:0]       rd_cnt;
    logic             pred_taken;
    logic             pr_taken_reg;
    logic [IDX_W-1:0] pr_idx_reg;

    assign is_br  = bus.if_valid && (bus.if_ir[6:0] == OP_BRANCH);
    assign pc_idx = bus.if_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
    // History advances only on resolved branches, never speculatively.
    logic [GHR_BITS-1:0] ghr_reg;

    always_ff @(posedge clk) begin
        if (rst)                ghr_reg <= '0;
        else if (bus.upd_valid) ghr_reg <= {ghr_reg[GHR_BITS-2:0], bus.upd_taken};
    end

    assign idx = pc_idx ^ IDX_W'(ghr_reg);
`else
    assign idx = pc_idx;
`endif

    bht_array #(
        .ENTRIES  (BHT_ENTRIES),
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk      (clk),
        .srst     (rst),
        .rd_idx   (idx),
        .rd_cnt   (rd_cnt),
        .wr_en    (bus.upd_valid),
        .wr_idx   (bus.upd_idx),
        .wr_taken (bus.upd_taken)
    );

    assign pred_taken        = is_br && rd_cnt[1];
    assign bus.pred_taken_if = pred_taken;
    assign bus.pred_addr_if  = pred_taken ? bus.if_pc + b_offset(bus.if_ir)
                                          : bus.if_pc + 64'd4;

    // Flush kills the prediction but keeps the index; stall freezes both.
    always_ff @(posedge clk) begin
        if (rst) begin
            pr_taken_reg <= 1'b0;
            pr_idx_reg   <= '0;
        end else if (bus.flush_if) begin
            pr_taken_reg <= 1'b0;
        end else if (!bus.stall_if) begin
            pr_taken_reg <= pred_taken;
            pr_idx_reg   <= idx;
        end
    end

    assign bus.pr_taken = pr_taken_reg;
    assign bus.pr_idx   = pr_idx_reg;

endmodule

// File: tb/tb_branch_pred.sv
// Directed bench for branch_pred: vector table for lookup/training, plus
// hand sequences for stall/flush, reset and (with BP_GSHARE_EN) the history hash.
module tb_branch_pred;

    localparam logic [31:0] BEQ16 = 32'h00208863;  // beq x1,x2,+16
    localparam logic [31:0] BEQM4 = 32'hFE000EE3;  // beq x0,x0,-4
    localparam logic [31:0] ADDI  = 32'h00000013;  // nop

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    branch_pred_if #(.IDX_W(8)) bus ();

    branch_pred #(
        .BHT_ENTRIES (256),
        .CNT_INIT    (2'b01),
        .GHR_BITS    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ir;
        logic        valid;
        logic        uv;
        logic [7:0]  ui;
        logic        ut;
        logic        et;
        logic [63:0] ea;
    } vec_t;

    localparam int NV = 20;
    vec_t v [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] ir, input logic valid);
        bus.if_pc    = pc;
        bus.if_ir    = ir;
        bus.if_valid = valid;
    endtask

    task automatic upd(input logic uv, input logic [7:0] ui, input logic ut);
        bus.upd_valid = uv;
        bus.upd_idx   = ui;
        bus.upd_taken = ut;
    endtask

    initial begin
        logic [63:0] stall_pcs [3];
        stall_pcs[0] = 64'h1000;
        stall_pcs[1] = 64'h3008;
        stall_pcs[2] = 64'h0;

        rst = 1'b1;
        drive(64'h1000, BEQ16, 1'b1);
        upd(1'b0, 8'h00, 1'b0);
        bus.stall_if = 1'b0;
        bus.flush_if = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pr_taken", {63'd0, bus.pr_taken}, 64'd0);
        chk("rst_pr_idx", {56'd0, bus.pr_idx}, 64'd0);
        chk("rst_pred_taken", {63'd0, bus.pred_taken_if}, 64'd0);
        rst = 1'b0;

`ifdef BP_GSHARE_EN
        drive(64'h18, BEQ16, 1'b0);
        upd(1'b1, 8'h00, 1'b1); tick();
        upd(1'b1, 8'h00, 1'b1); tick();
        upd(1'b1, 8'h00, 1'b0); tick();
        upd(1'b0, 8'h00, 1'b0);
        drive(64'h18, BEQ16, 1'b1);
        #1;
        chk("gshare_pred_taken", {63'd0, bus.pred_taken_if}, 64'd1);
        chk("gshare_pred_addr", bus.pred_addr_if, 64'h28);
        tick();
        chk("gshare_pr_idx", {56'd0, bus.pr_idx}, 64'd0);
        chk("gshare_pr_taken", {63'd0, bus.pr_taken}, 64'd1);
        $display("gshare lookup pc=0x18 pr_idx=%h pr_taken=%b", bus.pr_idx, bus.pr_taken);
`else
        //          pc           ir     vld   uv    ui     ut    et    ea
        v[0]  = '{64'h1000, BEQ16, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 64'h1004};
        v[1]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 64'h2008};
        v[2]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 64'h2008};
        v[3]  = '{64'h1000, BEQ16, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 64'h1010};
        v[4]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 64'h2008};
        v[5]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 64'h2008};
        v[6]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 64'h2008};
        v[7]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 64'h2008};
        v[8]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 64'h2008};
        v[9]  = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 64'h2008};
        v[10] = '{64'h1000, BEQ16, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 64'h1010};
        v[11] = '{64'h0000, BEQM4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
        v[12] = '{64'h1000, ADDI,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 64'h1004};
        v[13] = '{64'h1000, BEQ16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 64'h1004};
        v[14] = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 64'h2014};
        v[15] = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 64'h2008};
        v[16] = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 64'h2008};
        v[17] = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 64'h2008};
        v[18] = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 64'h2008};
        v[19] = '{64'h2004, BEQ16, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 64'h2014};

        for (int i = 0; i < NV; i++) begin
            drive(v[i].pc, v[i].ir, v[i].valid);
            upd(v[i].uv, v[i].ui, v[i].ut);
            #1;
            chk($sformatf("vec%0d_pred_taken", i), {63'd0, bus.pred_taken_if}, {63'd0, v[i].et});
            chk($sformatf("vec%0d_pred_addr", i), bus.pred_addr_if, v[i].ea);
            tick();
            chk($sformatf("vec%0d_pr_taken", i), {63'd0, bus.pr_taken}, {63'd0, v[i].et});
            chk($sformatf("vec%0d_pr_idx", i), {56'd0, bus.pr_idx}, {56'd0, v[i].pc[9:2]});
            $display("vec %0d pc=%h upd=%b/%h/%b pred=%b addr=%h", i, v[i].pc, v[i].uv,
                     v[i].ui, v[i].ut, bus.pr_taken, bus.pred_addr_if);
        end
        upd(1'b0, 8'h00, 1'b0);

        // Load a taken prediction at idx 1, then freeze it across a stall.
        drive(64'h2004, BEQ16, 1'b1);
        #1;
        chk("stall_load_pred", {63'd0, bus.pred_taken_if}, 64'd1);
        tick();
        chk("stall_load_pr_idx", {56'd0, bus.pr_idx}, 64'd1);
        bus.stall_if = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(stall_pcs[i], BEQ16, 1'b1);
            tick();
            chk($sformatf("stall%0d_pr_taken", i), {63'd0, bus.pr_taken}, 64'd1);
            chk($sformatf("stall%0d_pr_idx", i), {56'd0, bus.pr_idx}, 64'd1);
            $display("stall cycle %0d pc=%h pr_taken=%b pr_idx=%h", i, stall_pcs[i], bus.pr_taken, bus.pr_idx);
        end
        bus.flush_if = 1'b1;
        drive(64'h1000, BEQ16, 1'b1);
        tick();
        chk("flush_stall_pr_taken", {63'd0, bus.pr_taken}, 64'd0);
        chk("flush_stall_pr_idx", {56'd0, bus.pr_idx}, 64'd1);
        bus.stall_if = 1'b0;
        tick();
        chk("flush_pr_taken", {63'd0, bus.pr_taken}, 64'd0);
        chk("flush_pr_idx", {56'd0, bus.pr_idx}, 64'd1);
        $display("flush pr_taken=%b pr_idx=%h", bus.pr_taken, bus.pr_idx);

        // Training during a stall still reaches the table.
        bus.flush_if = 1'b0;
        bus.stall_if = 1'b1;
        upd(1'b1, 8'h02, 1'b1);
        tick();
        chk("stall_upd_pr_idx", {56'd0, bus.pr_idx}, 64'd1);
        upd(1'b0, 8'h00, 1'b0);
        bus.stall_if = 1'b0;
        drive(64'h3008, BEQ16, 1'b1);
        #1;
        chk("stall_upd_pred", {63'd0, bus.pred_taken_if}, 64'd1);
        chk("stall_upd_addr", bus.pred_addr_if, 64'h3018);
        tick();
        chk("stall_upd_pr_idx2", {56'd0, bus.pr_idx}, 64'd2);
        $display("train-in-stall idx=02 pr_taken=%b", bus.pr_taken);

        // Reset with an update pending: counters return to weakly not-taken.
        rst = 1'b1;
        drive(64'h1000, BEQ16, 1'b1);
        upd(1'b1, 8'h00, 1'b1);
        tick();
        chk("mid_rst_pr_taken", {63'd0, bus.pr_taken}, 64'd0);
        chk("mid_rst_pr_idx", {56'd0, bus.pr_idx}, 64'd0);
        upd(1'b0, 8'h00, 1'b0);
        #1;
        chk("mid_rst_pred_in_rst", {63'd0, bus.pred_taken_if}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_idx0_pred", {63'd0, bus.pred_taken_if}, 64'd0);
        chk("post_rst_idx0_addr", bus.pred_addr_if, 64'h1004);
        drive(64'h2004, BEQ16, 1'b1);
        #1;
        chk("post_rst_idx1_pred", {63'd0, bus.pred_taken_if}, 64'd0);
        $display("reset with pending update: pred=%b", bus.pred_taken_if);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_pred.md
# branch_pred

Fetch-stage dynamic branch predictor for the rv6 core, directly upstream of the ID-stage branch ALU. It predicts taken/not-taken for conditional branches (`OP_BRANCH`) in IF using a table of 2-bit saturating counters, and produces the next-fetch redirect address. It registers the prediction and table index into the IF/ID boundary, where `pr_taken` is consumed by the branch ALU. Resolved outcomes come back from ID and train the table.

## Interface
- `BHT_ENTRIES`, 256: number of counters; power of two, ≥4. `IDX_W = log2(BHT_ENTRIES)`.
- `CNT_INIT`, 2'b01: counter reset value (weakly not-taken).
- `GHR_BITS`, 8: global history length; used only with `BP_GSHARE_EN`; must be ≤ `IDX_W`.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_pc` in 64: PC of the instruction in IF.
- `if_ir` in 32: instruction word in IF.
- `if_valid` in 1: `if_ir` is valid.
- `stall_if` in 1: hold the IF/ID prediction registers.
- `flush_if` in 1: kill the instruction entering ID.
- `pred_taken_if` out 1: combinational IF prediction.
- `pred_addr_if` out 64: combinational next fetch PC.
- `pr_taken` out 1: registered prediction for the instruction in ID.
- `pr_idx` out `IDX_W`: registered table index for the instruction in ID.
- `upd_valid` in 1: a conditional branch resolved in ID this cycle.
- `upd_idx` in `IDX_W`: its `pr_idx`.
- `upd_taken` in 1: actual outcome, `pr_taken ^ pr_miss`.

## Operation
- Branch detect: `is_br = if_valid && if_ir[6:0] == OP_BRANCH`.
- Lookup index:
  - Without `BP_GSHARE_EN`: `idx = if_pc[IDX_W+1:2]`.
  - With `BP_GSHARE_EN`: `if_pc[IDX_W+1:2] ^ {zeros, ghr}`.
- Offset: B-immediate `{{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}`, sign-extended to 64 bits.
- Prediction:
  - `pred_taken_if = is_br && cnt[idx][1]`.
  - `pred_addr_if = pred_taken_if ? if_pc + offset : if_pc + 4`. All adds are modulo 2^64, so wrap-around is silent.
- Counter update when `upd_valid` is high:
  - Taken: `cnt = (cnt == 3) ? 3 : cnt + 1`.
  - Not taken: `cnt = (cnt == 0) ? 0 : cnt - 1`.
  - Saturation is mandatory; no wrap from 3 to 0 or 0 to 3.
- Forwarding: if `upd_valid && upd_idx == idx` in the same cycle, the lookup uses the updated counter value, not the stale one.
- IF/ID registers, priority order:
  1. `rst`: `pr_taken = 0`, `pr_idx = 0`.
  2. `flush_if`: `pr_taken = 0`, `pr_idx` holds.
  3. `stall_if`: both hold.
  4. Otherwise: `pr_taken = pred_taken_if`, `pr_idx = idx`.
- Non-branch instructions load `pr_taken = 0`.
- Training is independent of `stall_if` and `flush_if`. An update presented during a stall or flush is still applied.
- Reset: every counter = `CNT_INIT`, `ghr = 0`, `pr_taken = 0`, `pr_idx = 0`.
  - `pred_taken_if` during reset follows `CNT_INIT[1]` after the first reset edge.
  - Reset mid-update discards the update.

## Timing
- Lookup: 0 cycles. `pred_*_if` is a combinational function of `if_pc`, `if_ir`, table state, and the forwarded update.
- `pr_taken` / `pr_idx`: 1 cycle after IF, aligned with the instruction in ID.
- Update: the counter is written at the edge where `upd_valid` is sampled. It is visible to lookups in the same cycle via forwarding, and from the table afterwards.
- Back-to-back updates to the same index on consecutive cycles each apply, for a cumulative ±2.
- No handshakes. `upd_valid` is a single-cycle pulse per resolved branch.

## Configuration
- `BP_GSHARE_EN` defined:
  - Adds the `GHR_BITS` global history register.
  - On each `upd_valid`: `ghr <= {ghr[GHR_BITS-2:0], upd_taken}`.
  - Lookup index is XOR-hashed with `ghr`.
  - History is non-speculative: it is updated only at resolution.
- `BP_GSHARE_EN` undefined: no GHR, and the index is pure PC bits.
- The port list is identical in both builds.

## Structure
- `OP_BRANCH` comes from `config.vh`. The counter encodings (`BP_SNT=0`, `BP_WNT=1`, `BP_WT=2`, `BP_ST=3`) are added there too.
- One sub-module, `bht_array`: holds the counter storage, synchronous reset, saturating read-modify-write, and same-cycle forwarding.
- `branch_pred` contains decode, hashing, target add, and the IF/ID registers.

## Test plan
- Reset, then present a branch at `if_pc=0x1000`, `if_ir=beq x1,x2,+16` → `pred_taken_if=0`, `pred_addr_if=0x1004`; next cycle `pr_taken=0`.
- Two taken updates to idx 0x00 → same branch gives `pred_taken_if=1`, `pred_addr_if=0x1010`. Five more taken updates, then one not-taken → still predicts taken (saturated at 3, now at 2).
- Backward branch at `if_pc=0x0`, offset −4 → `pred_addr_if=0xFFFF_FFFF_FFFF_FFFC` when taken.
- Counter at 1, `upd_valid=1`, `upd_taken=1`, same idx as lookup in the same cycle → `pred_taken_if=1` (forwarded).
- `stall_if=1` for 3 cycles with a changing `if_pc` → `pr_taken` and `pr_idx` hold. `flush_if` together with `stall_if` → `pr_taken=0`.
- With `BP_GSHARE_EN`: updates taken, taken, not-taken → `ghr=3'b110` in the low bits. Lookup at `if_pc=0x18` uses idx `0x06 ^ 0x06 = 0x00`.
